// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command and result channels of the ALU issue controller
//
// Purpose: bundles the command valid/ready channel and the result valid/ready
// channel so the issue controller and its upstream/downstream share one port.
// Ports:
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/rd/rs1/rs2/use_imm/imm command fields
//   res_valid/res_ready           result handshake
//   res_data/res_rd               result value and destination register
//   res_zero/res_neg              result flags (only with ALU_ISSUE_FLAGS_EN)
// Modports: slave = issue controller, master = command source / result sink.
// Optional feature macro: ALU_ISSUE_FLAGS_EN.

interface alu_issue_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [RA_W-1:0]   cmd_rd;
  logic [RA_W-1:0]   cmd_rs1;
  logic [RA_W-1:0]   cmd_rs2;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [RA_W-1:0]   res_rd;
`ifdef ALU_ISSUE_FLAGS_EN
  logic              res_zero;
  logic              res_neg;
`endif

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output res_valid, res_data, res_rd,
`ifdef ALU_ISSUE_FLAGS_EN
    output res_zero, res_neg,
`endif
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  res_valid, res_data, res_rd,
`ifdef ALU_ISSUE_FLAGS_EN
    input  res_zero, res_neg,
`endif
    output res_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue stage and register file for the 8-bit combinational ALU
//
// Purpose: accepts one register-style command at a time, drives the ALU for a
// single EXEC cycle, writes the ALU result back to the register file and
// presents it on the result channel until the sink accepts it.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         command/result channels (alu_issue_ctrl_if.slave)
//   alu_a/alu_b operands to the ALU (0 outside EXEC)
//   alu_opcode  opcode to the ALU (3'b111 outside EXEC, forcing a 0 result)
//   alu_result  combinational ALU output
// Optional feature macro: ALU_ISSUE_FLAGS_EN adds res_zero/res_neg result flags.

module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] regs [NREGS];

  logic [2:0]        op_q;
  logic [RA_W-1:0]   rd_q;
  logic [RA_W-1:0]   rs1_q;
  logic [RA_W-1:0]   rs2_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q;

  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic [RA_W-1:0]   res_rd_q;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;

`ifdef ALU_ISSUE_FLAGS_EN
  logic res_zero_q;
  logic res_neg_q;
  assign bus.res_zero = res_zero_q;
  assign bus.res_neg  = res_neg_q;
`endif

  // Operands are read before write-back, so rd == rs1/rs2 sees the old value.
  // Idle opcode 111 keeps the ALU output at zero when nothing is issued.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = 3'b111;
    if (state == EXEC) begin
      alu_a      = regs[rs1_q];
      alu_b      = use_imm_q ? imm_q : regs[rs2_q];
      alu_opcode = op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q      <= bus.cmd_op;
            rd_q      <= bus.cmd_rd;
            rs1_q     <= bus.cmd_rs1;
            rs2_q     <= bus.cmd_rs2;
            use_imm_q <= bus.cmd_use_imm;
            imm_q     <= bus.cmd_imm;
            state     <= EXEC;
          end
        end
        EXEC: begin
          regs[rd_q]  <= alu_result;
          res_data_q  <= alu_result;
          res_rd_q    <= rd_q;
          res_valid_q <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
          res_zero_q  <= (alu_result == '0);
          res_neg_q   <= alu_result[DATA_W-1];
`endif
          state       <= RESP;
        end
        RESP: begin
          // Result fields stay untouched here, so they hold under backpressure.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed-vector bench for alu_issue_ctrl with a behavioural ALU

module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  alu_issue_ctrl_if #(.DATA_W(8), .RA_W(2)) bus ();

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, else 0.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_a << alu_b[2:0];
      3'b110:  alu_result = alu_a * alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge inside EXEC.
  task automatic send_cmd(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic use_imm, input logic [7:0] imm);
    check({tag, "/cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_rd      = rd;
    bus.cmd_rs1     = rs1;
    bus.cmd_rs2     = rs2;
    bus.cmd_use_imm = use_imm;
    bus.cmd_imm     = imm;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic use_imm, input logic [7:0] imm,
                       input logic [7:0] exp_a, input logic [7:0] exp_b,
                       input logic [7:0] exp_data, input int hold);
    send_cmd(tag, op, rd, rs1, rs2, use_imm, imm);
    check({tag, "/exec_opcode"}, 32'(alu_opcode), 32'(op));
    check({tag, "/exec_a"}, 32'(alu_a), 32'(exp_a));
    check({tag, "/exec_b"}, 32'(alu_b), 32'(exp_b));
    check({tag, "/exec_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "/exec_ready"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check({tag, "/res_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "/res_data"}, 32'(bus.res_data), 32'(exp_data));
    check({tag, "/res_rd"}, 32'(bus.res_rd), 32'(rd));
`ifdef ALU_ISSUE_FLAGS_EN
    check({tag, "/res_zero"}, 32'(bus.res_zero), 32'(exp_data == 8'h00));
    check({tag, "/res_neg"}, 32'(bus.res_neg), 32'(exp_data[7]));
`endif
    // Backpressure: a stray command pulsed mid-hold (writes 0x77 to r0) must be ignored.
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'b000;
        bus.cmd_rd      = 2'd0;
        bus.cmd_rs1     = 2'd0;
        bus.cmd_use_imm = 1'b1;
        bus.cmd_imm     = 8'h77;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "/hold_data"}, 32'(bus.res_data), 32'(exp_data));
      check({tag, "/hold_rd"}, 32'(bus.res_rd), 32'(rd));
      check({tag, "/hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, "/done_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "/done_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // Register read-back: ADD rd=r, rs1=r, imm=0 rewrites r with its own value.
  task automatic read_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
    issue(tag, 3'b000, r, r, r, 1'b1, 8'h00, exp, 8'h00, exp, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "/rst_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "/rst_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "/rst_data"}, 32'(bus.res_data), 32'd0);
    check({tag, "/rst_opcode"}, 32'(alu_opcode), 32'd7);
  endtask

  initial begin
    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 3'b000;
    bus.cmd_rd      = 2'd0;
    bus.cmd_rs1     = 2'd0;
    bus.cmd_rs2     = 2'd0;
    bus.cmd_use_imm = 1'b0;
    bus.cmd_imm     = 8'h00;
    bus.res_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset/cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset/res_valid", 32'(bus.res_valid), 32'd0);
    check("reset/res_data", 32'(bus.res_data), 32'd0);
    check("reset/res_rd", 32'(bus.res_rd), 32'd0);
    check("reset/alu_a", 32'(alu_a), 32'd0);
    check("reset/alu_b", 32'(alu_b), 32'd0);
    check("reset/alu_opcode", 32'(alu_opcode), 32'd7);
`ifdef ALU_ISSUE_FLAGS_EN
    check("reset/res_zero", 32'(bus.res_zero), 32'd0);
    check("reset/res_neg", 32'(bus.res_neg), 32'd0);
`endif

    // r1 = 0 + 5
    issue("add_imm", 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05, 0);
    // r2 = 0 - 5 = 0xFB
    issue("sub_wrap", 3'b001, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h00, 8'h05, 8'hFB, 0);
    // r1 = 5 * 0xFB = 0x4E7 -> 0xE7, old r1 used as operand; 4 cycles of backpressure
    issue("mul_hold", 3'b110, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 8'h05, 8'hFB, 8'hE7, 4);
    read_reg("rb_r0_stray", 2'd0, 8'h00);
    read_reg("rb_r1_mul", 2'd1, 8'hE7);
    read_reg("rb_r2_sub", 2'd2, 8'hFB);

    // Opcode 111 writes 0 over a preloaded r3
    issue("preload_r3", 3'b000, 2'd3, 2'd0, 2'd0, 1'b1, 8'h2A, 8'h00, 8'h2A, 8'h2A, 0);
    issue("op111", 3'b111, 2'd3, 2'd3, 2'd0, 1'b1, 8'h09, 8'h2A, 8'h09, 8'h00, 0);
    read_reg("rb_r3_op111", 2'd3, 8'h00);

    // Reset while in EXEC: no write-back of 0x55, file cleared
    send_cmd("rst_exec", 3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 8'h55);
    check("rst_exec/in_exec", 32'(alu_opcode), 32'd0);
    pulse_reset("rst_exec");
    read_reg("rb_exec_r1", 2'd1, 8'h00);
    read_reg("rb_exec_r2", 2'd2, 8'h00);

    // Reset while in RESP with a pending result
    issue("preload_r1", 3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h11, 8'h00, 8'h11, 8'h11, 0);
    send_cmd("rst_resp", 3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01);
    @(negedge clk);
    check("rst_resp/pending_valid", 32'(bus.res_valid), 32'd1);
    check("rst_resp/pending_data", 32'(bus.res_data), 32'h12);
    pulse_reset("rst_resp");
    read_reg("rb_resp_r1", 2'd1, 8'h00);
    read_reg("rb_resp_r3", 2'd3, 8'h00);
    read_reg("rb_resp_r0", 2'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
